// File: rtl/mod_sqr_seq_pkg.sv
// Shared types and default sizes for the repeated modular squaring sequencer.
// Latency: n/a (declarations only).  Backpressure: n/a.
package mod_sqr_seq_pkg;

  localparam int BITS_DEF  = 392;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mod_sqr_seq.sv
// Computes x^(2^T) mod M by T squarings through an external modular multiplier.
// Latency: T*(mul latency + 2) + 1 cycles from accept; T==0 answers the next cycle.
// Backpressure: one request outstanding, operands/result held until ready; MOD_SQR_SEQ_PERF_EN adds o_cyc_cnt.
module mod_sqr_seq
  import mod_sqr_seq_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_val,
  output logic             o_rdy,
  input  logic [BITS-1:0]  i_dat,
  input  logic [CNT_W-1:0] i_iter,
  output logic             o_mul_val,
  input  logic             i_mul_rdy,
  output logic [BITS-1:0]  o_mul_a,
  output logic [BITS-1:0]  o_mul_b,
  input  logic             i_mul_val,
  output logic             o_mul_rdy,
  input  logic [BITS-1:0]  i_mul_dat,
  output logic             o_val,
  input  logic             i_rdy,
  output logic [BITS-1:0]  o_dat
`ifdef MOD_SQR_SEQ_PERF_EN
  ,
  output logic [31:0]      o_cyc_cnt
`endif
);

  state_t           state, state_nxt;
  logic [BITS-1:0]  acc;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             mul_ret;

  assign accept  = i_val && (state == ST_IDLE);
  assign mul_ret = i_mul_val && (state == ST_WAIT);
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    o_rdy     = 1'b0;
    o_mul_val = 1'b0;
    o_mul_rdy = 1'b0;
    o_val     = 1'b0;
    case (state)
      ST_IDLE: begin
        o_rdy = 1'b1;
        if (i_val) state_nxt = (i_iter == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        o_mul_val = 1'b1;
        if (i_mul_rdy) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        o_mul_rdy = 1'b1;
        // cnt+1 compared before the increment lands, so T = all-ones never wraps cnt
        if (i_mul_val) state_nxt = (cnt_inc == tgt) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        o_val = 1'b1;
        if (i_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)       cnt <= '0;
      else if (mul_ret) cnt <= cnt_inc;
    end
  end

  // Datapath carries no reset; it is always loaded on accept before use.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      acc <= i_dat;
      tgt <= i_iter;
    end else if (mul_ret) begin
      acc <= i_mul_dat;
    end
  end

  assign o_mul_a = acc;
  assign o_mul_b = acc;
  assign o_dat   = acc;

`ifdef MOD_SQR_SEQ_PERF_EN
  logic [31:0] cyc_cnt;

  // The accept cycle itself counts as the first cycle of the job.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cyc_cnt <= '0;
    end else if (accept) begin
      cyc_cnt <= 32'd1;
    end else if ((state == ST_ISSUE || state == ST_WAIT) && (cyc_cnt != '1)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign o_cyc_cnt = cyc_cnt;
`endif

endmodule
